// File: rtl/present_ksa_ctrl.sv
// PRESENT-80 key-schedule sequencer: owns the key register and round counter and streams
// the 32 round keys to the cipher datapath over a registered valid/ready handshake.
module present_ksa_ctrl #(
    parameter int KEY_W  = 80,
    parameter int RK_W   = 64,
    parameter int NUM_RK = 32,
    parameter int RC_W   = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [KEY_W-1:0] key_in,
    output logic [RK_W-1:0]  rk_out,
    output logic [5:0]       rk_idx,
    output logic             rk_valid,
    input  logic             rk_ready,
    output logic             rk_last,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EMIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [5:0] LAST_IDX = 6'(NUM_RK);

    state_t           state_q;
    logic [KEY_W-1:0] key_q;
    logic [KEY_W-1:0] key_d;
    logic [KEY_W-1:0] key_rot;
    logic [5:0]       idx_q;
    logic             valid_q;
    logic             last_q;
    logic             busy_q;
    logic             done_q;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
            4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
            4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
            4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  default: y = 4'h2;
        endcase
        return y;
    endfunction

    // One KSA round: rotate left 61, S-box the top nibble, mix the round counter.
    always_comb begin
        key_rot                          = {key_q[18:0], key_q[KEY_W-1:19]};
        key_d                            = key_rot;
        key_d[KEY_W-1:KEY_W-4]           = sbox(key_rot[KEY_W-1:KEY_W-4]);
        key_d[15+RC_W-1:15]              = key_rot[15+RC_W-1:15] ^ idx_q[RC_W-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            key_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q <= ST_EMIT;
                        key_q   <= key_in;
                        idx_q   <= 6'd1;
                        valid_q <= 1'b1;
                        last_q  <= (LAST_IDX == 6'd1);
                        busy_q  <= 1'b1;
                    end
                end
                ST_EMIT: begin
                    // abort wins over a transfer in the same cycle
                    if (abort) begin
                        state_q <= ST_IDLE;
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                        busy_q  <= 1'b0;
                    end else if (rk_ready) begin
                        if (idx_q == LAST_IDX) begin
                            state_q <= ST_DONE;
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            key_q  <= key_d;
                            idx_q  <= idx_q + 6'd1;
                            last_q <= (idx_q + 6'd1 == LAST_IDX);
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    valid_q <= 1'b0;
                    last_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rk_out   = key_q[KEY_W-1:KEY_W-RK_W];
    assign rk_idx   = idx_q;
    assign rk_valid = valid_q;
    assign rk_last  = last_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_present_ksa_ctrl.sv
// Bench for present_ksa_ctrl: directed sequence with randomized keys and stalls,
// checked against a behavioural PRESENT-80 key-schedule model.
module tb_present_ksa_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic [79:0] key_in;
    logic [63:0] rk_out;
    logic [5:0]  rk_idx;
    logic        rk_valid;
    logic        rk_ready;
    logic        rk_last;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    present_ksa_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .abort    (abort),
        .key_in   (key_in),
        .rk_out   (rk_out),
        .rk_idx   (rk_idx),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .rk_last  (rk_last),
        .busy     (busy),
        .done     (done)
    );

    localparam logic [3:0] SBOX [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                         4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

    // Reference round: arithmetic rotation, table S-box, counter XOR at bit 15.
    function automatic logic [79:0] ksa_ref(input logic [79:0] k, input int i);
        logic [79:0] r;
        logic [3:0]  top;
        r   = (k << 61) | (k >> 19);
        top = 4'(r >> 76);
        r   = (r & ~(80'hF << 76)) | (80'(SBOX[top]) << 76);
        r   = r ^ (80'(i % 32) << 15);
        return r;
    endfunction

    function automatic logic [63:0] gold_zero_key(input int i);
        logic [63:0] g;
        case (i)
            1:       g = 64'h0000000000000000;
            2:       g = 64'hc000000000000000;
            3:       g = 64'h5000180000000001;
            default: g = 64'h6dab31744f41d700;
        endcase
        return g;
    endfunction

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_valid"}, 80'(rk_valid), 80'(0));
        chk({tag, "_busy"},  80'(busy),     80'(0));
        chk({tag, "_done"},  80'(done),     80'(0));
        chk({tag, "_last"},  80'(rk_last),  80'(0));
    endtask

    // One full schedule from an IDLE cycle; optional stalls, abort at an index, stray starts.
    task automatic run_sched(input logic [79:0] key, input int max_stall,
                             input int abort_idx, input bit poke);
        logic [63:0] exp_rk [1:32];
        logic [79:0] k;
        int          e;
        int          stall;
        int          cyc;
        bit          rdy;
        bit          ab;
        k = key;
        for (int i = 1; i <= 32; i++) begin
            exp_rk[i] = k[79:16];
            k = ksa_ref(k, i);
        end
        start  = 1'b1;
        key_in = key;
        step();
        start  = 1'b0;
        key_in = 80'({$urandom, $urandom, $urandom});
        e      = 1;
        stall  = int'($urandom_range(0, max_stall));
        cyc    = 0;
        forever begin
            cyc = cyc + 1;
            if (cyc > 1000) begin
                checks = checks + 1;
                errors = errors + 1;
                $error("FAIL timeout observed_idx=%0d expected_idx=%0d", rk_idx, e);
                return;
            end
            chk("valid", 80'(rk_valid), 80'(1));
            chk("idx",   80'(rk_idx),   80'(e));
            chk("rk",    80'(rk_out),   80'(exp_rk[e]));
            chk("last",  80'(rk_last),  80'(e == 32));
            chk("busy",  80'(busy),     80'(1));
            chk("done_emit", 80'(done), 80'(0));
            if (key == 80'h0 && (e <= 3 || e == 32))
                chk("golden", 80'(rk_out), 80'(gold_zero_key(e)));
            rdy = (stall == 0);
            if (!rdy) stall = stall - 1;
            ab       = (e == abort_idx) && rdy;
            rk_ready = rdy;
            abort    = ab;
            start    = poke ? 1'($urandom_range(0, 1)) : 1'b0;
            step();
            abort = 1'b0;
            start = 1'b0;
            if (ab) begin
                chk_idle_outputs("abort");
                return;
            end
            if (rdy) begin
                if (e == 32) break;
                e     = e + 1;
                stall = int'($urandom_range(0, max_stall));
            end
        end
        rk_ready = 1'($urandom_range(0, 1));
        chk("done_pulse", 80'(done),     80'(1));
        chk("done_valid", 80'(rk_valid), 80'(0));
        chk("done_busy",  80'(busy),     80'(1));
        chk("done_last",  80'(rk_last),  80'(0));
        start = poke;
        step();
        start = 1'b0;
        chk_idle_outputs("post_done");
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        rk_ready = 1'b0;
        key_in   = '0;
        #1;
        chk("rst_rk",  80'(rk_out), 80'(0));
        chk("rst_idx", 80'(rk_idx), 80'(0));
        chk_idle_outputs("rst");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        step();
        chk_idle_outputs("idle");

        run_sched(80'h0, 0, 0, 1'b0);
        run_sched(80'hffff_ffffffffffffffff, 5, 0, 1'b0);
        run_sched(80'({$urandom, $urandom, $urandom}), 3, 0, 1'b1);
        // starts in the IDLE cycle right after done, then aborted at idx 10
        run_sched(80'h0, 0, 10, 1'b0);
        run_sched(80'h0, 2, 0, 1'b0);

        start    = 1'b1;
        abort    = 1'b1;
        key_in   = 80'h0;
        rk_ready = 1'b1;
        step();
        start  = 1'b0;
        abort  = 1'b0;
        key_in = 80'({$urandom, $urandom, $urandom});
        chk("sa_valid", 80'(rk_valid), 80'(1));
        chk("sa_idx",   80'(rk_idx),   80'(1));
        chk("sa_rk",    80'(rk_out),   80'(0));
        repeat (16) step();
        chk("mid_idx", 80'(rk_idx), 80'(17));
        #2;
        reset = 1'b1;
        #1;
        chk("arst_rk",  80'(rk_out), 80'(0));
        chk("arst_idx", 80'(rk_idx), 80'(0));
        chk_idle_outputs("arst");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk_idle_outputs("stay_idle");
            chk("stay_idx", 80'(rk_idx), 80'(0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
